// File: rtl/johnson_decoder_4bit.sv
// 4-bit Johnson codeword decoder with HUNT/SYNC/LOCKED alignment FSM and saturating error count.
// Latency: 1 cycle, all outputs registered. Backpressure: none; din_valid low stalls the tracker.
module johnson_decoder_4bit #(
    parameter int LOCK_CNT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] din,
    input  logic       din_valid,
    input  logic       err_clr,
    output logic [2:0] phase,
    output logic       phase_valid,
    output logic       code_err,
    output logic       seq_err,
    output logic       locked,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

    localparam logic [2:0] LOCK_TH = 3'(LOCK_CNT);

    state_t     state;
    logic [2:0] ref_idx;
    logic [2:0] good_cnt;
    logic       ref_keep;

    logic       legal;
    logic [2:0] idx;
    logic [2:0] succ_idx;
    logic [2:0] cnt_inc;
    logic       in_order;
    logic       err_hit;

    always_comb begin
        legal = 1'b1;
        idx   = 3'd0;
        case (din)
            4'b0000: idx = 3'd0;
            4'b1000: idx = 3'd1;
            4'b1100: idx = 3'd2;
            4'b1110: idx = 3'd3;
            4'b1111: idx = 3'd4;
            4'b0111: idx = 3'd5;
            4'b0011: idx = 3'd6;
            4'b0001: idx = 3'd7;
            default: legal = 1'b0;
        endcase
    end

    // 3-bit add wraps 7 -> 0, so the wrap counts as in order
    assign succ_idx = ref_idx + 3'd1;
    assign cnt_inc  = good_cnt + 3'd1;
    assign in_order = (idx == succ_idx);
    assign err_hit  = din_valid && (!legal || (state != HUNT && !in_order));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HUNT;
            ref_idx     <= 3'd0;
            good_cnt    <= 3'd0;
            ref_keep    <= 1'b0;
            phase       <= 3'd0;
            phase_valid <= 1'b0;
            code_err    <= 1'b0;
            seq_err     <= 1'b0;
            locked      <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            phase_valid <= 1'b0;
            code_err    <= 1'b0;
            seq_err     <= 1'b0;

            if (err_clr)
                err_count <= 8'd0;
            else if (err_hit && err_count != 8'hFF)
                err_count <= err_count + 8'd1;

            if (din_valid) begin
                if (legal) begin
                    phase       <= idx;
                    phase_valid <= 1'b1;
                    ref_idx     <= idx;
                end else begin
                    code_err    <= 1'b1;
                end

                case (state)
                    HUNT: begin
                        ref_keep <= 1'b0;
                        if (legal) begin
                            state    <= SYNC;
                            // a reference kept from a lost lock lets this sample count as the second
                            good_cnt <= (ref_keep && in_order) ? 3'd2 : 3'd1;
                        end
                    end
                    SYNC: begin
                        if (!legal) begin
                            state    <= HUNT;
                            good_cnt <= 3'd0;
                        end else if (in_order) begin
                            good_cnt <= cnt_inc;
                            if (cnt_inc >= LOCK_TH) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            seq_err  <= 1'b1;
                            good_cnt <= 3'd1;
                        end
                    end
                    LOCKED: begin
                        if (!legal) begin
                            state    <= HUNT;
                            locked   <= 1'b0;
                            good_cnt <= 3'd0;
                            ref_keep <= 1'b0;
                        end else if (!in_order) begin
                            state    <= HUNT;
                            locked   <= 1'b0;
                            seq_err  <= 1'b1;
                            good_cnt <= 3'd0;
                            ref_keep <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
